// File: rtl/sns_pkg.sv
// Shared types and grid helpers for the stack-and-smash surface calculator.
// Holds the FSM state encoding, the grid dimension constants, the cell index and the neighbour arithmetic.
package sns_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, BLAST, SCAN, DONE} state_t;

  localparam int DIM_LOG2_DFLT = 3;
  localparam int N             = 1 << DIM_LOG2_DFLT;
  localparam int CELLS         = N * N * N;

  typedef struct packed {
    logic        vld;
    logic [31:0] c;
  } nbr_t;

  function automatic int grid_n(input int dl);
    return 1 << dl;
  endfunction

  function automatic int grid_cells(input int dl);
    return 1 << (3 * dl);
  endfunction

  function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                      input int unsigned z, input int unsigned dl);
    return (z << (2 * dl)) | (y << dl) | x;
  endfunction

  // One-axis step of +/-1. With wrap clear, stepping off the grid gives vld = 0.
  function automatic nbr_t nbr(input int unsigned c, input logic up,
                               input int unsigned n, input logic wrap);
    nbr_t r;
    r.vld = 1'b1;
    if (up) begin
      if (c == n - 1) begin
        r.vld = wrap;
        r.c   = 0;
      end else begin
        r.c   = c + 1;
      end
    end else begin
      if (c == 0) begin
        r.vld = wrap;
        r.c   = n - 1;
      end else begin
        r.c   = c - 1;
      end
    end
    return r;
  endfunction

  // Face neighbour d (0..5: +x,-x,+y,-y,+z,-z). The c field of the result is a cell index.
  function automatic nbr_t nbr_cell(input int unsigned x, input int unsigned y,
                                    input int unsigned z, input int unsigned d,
                                    input int unsigned dl, input logic wrap);
    nbr_t        r;
    int unsigned n;
    n = 32'd1 << dl;
    case (d / 2)
      0:       begin r = nbr(x, d[0] == 1'b0, n, wrap); r.c = idx(r.c, y, z, dl); end
      1:       begin r = nbr(y, d[0] == 1'b0, n, wrap); r.c = idx(x, r.c, z, dl); end
      default: begin r = nbr(z, d[0] == 1'b0, n, wrap); r.c = idx(x, y, r.c, dl); end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sns_face_count.sv
// Counts the occupied face neighbours (0..6) of one cell, clipping at the grid faces.
// Combinational, with zero latency and no backpressure.
module sns_face_count
  import sns_pkg::*;
#(
  parameter int DIM_LOG2 = 3
) (
  input  logic [(1 << (3 * DIM_LOG2)) - 1:0] occ,
  input  logic [DIM_LOG2-1:0]                x,
  input  logic [DIM_LOG2-1:0]                y,
  input  logic [DIM_LOG2-1:0]                z,
  output logic [2:0]                         k
);

  localparam int CW = 3 * DIM_LOG2;

  nbr_t nb;

  always_comb begin
    k  = 3'd0;
    nb = '0;
    for (int unsigned d = 0; d < 6; d++) begin
      nb = nbr_cell(32'(x), 32'(y), 32'(z), d, DIM_LOG2, 1'b0);
      if (nb.vld && occ[CW'(nb.c)]) begin
        k = k + 3'd1;
      end
    end
  end

endmodule

// File: rtl/sns_grid_area.sv
// Loads a voxel burst, detonates the bombs, then sums the weighted exposed faces over a 2-stage scan.
// out_valid comes 2*N^3+3 cycles after in_valid falls; beats that arrive while busy or in DONE are dropped.
module sns_grid_area
  import sns_pkg::*;
#(
  parameter int DIM_LOG2 = 3,
  parameter int NUM_W    = 3,
  parameter int SUM_W    = 16,
  parameter int WRAP     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DIM_LOG2-1:0] in_x,
  input  logic [DIM_LOG2-1:0] in_y,
  input  logic [DIM_LOG2-1:0] in_z,
  input  logic [NUM_W-1:0]    in_number,
  input  logic                bomb,
  output logic                busy,
  output logic                out_valid,
  output logic [SUM_W-1:0]    out_sum
);

  localparam int GRID_CELLS = grid_cells(DIM_LOG2);
  localparam int CW         = 3 * DIM_LOG2;
  localparam int CNTW       = CW + 1;
  localparam int PW         = 3 + NUM_W;
  localparam int EW         = ((SUM_W > PW) ? SUM_W : PW) + 1;

  state_t state_q, state_d;

  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [GRID_CELLS-1:0] occ_q, occ_d;
  logic [GRID_CELLS-1:0] bmb_q, bmb_d;
  logic [NUM_W-1:0]      num_q [GRID_CELLS];
  logic [NUM_W-1:0]      num_d [GRID_CELLS];
  logic                  s1_vld_q, s1_vld_d;
  logic [2:0]            s1_mul_q, s1_mul_d;
  logic [NUM_W-1:0]      s1_num_q, s1_num_d;
  logic [SUM_W-1:0]      acc_q, acc_d;

  logic [CW-1:0] cur;
  logic [CW-1:0] wi;
  logic [2:0]    k_w;
  logic [EW-1:0] sum_w;
  nbr_t          nb;

  assign cur = cnt_q[CW-1:0];

  sns_face_count #(
    .DIM_LOG2(DIM_LOG2)
  ) u_face_count (
    .occ(occ_q),
    .x  (cur[DIM_LOG2-1:0]),
    .y  (cur[2*DIM_LOG2-1:DIM_LOG2]),
    .z  (cur[CW-1:2*DIM_LOG2]),
    .k  (k_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    if (!in_valid) state_d = BLAST;
      BLAST:   if (cnt_q == CNTW'(GRID_CELLS - 1)) state_d = SCAN;
      SCAN:    if (cnt_q == CNTW'(GRID_CELLS + 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == BLAST) || (state_q == SCAN) || (state_q == DONE);
    out_valid = (state_q == DONE);
    out_sum   = (state_q == DONE) ? acc_q : '0;
  end

  always_comb begin
    occ_d    = occ_q;
    bmb_d    = bmb_q;
    num_d    = num_q;
    cnt_d    = '0;
    acc_d    = acc_q;
    s1_vld_d = 1'b0;
    s1_mul_d = '0;
    s1_num_d = '0;
    wi       = '0;
    nb       = '0;
    sum_w    = '0;
    case (state_q)
      IDLE, LOAD: begin
        if (in_valid) begin
          wi        = CW'(idx(32'(in_x), 32'(in_y), 32'(in_z), DIM_LOG2));
          occ_d[wi] = 1'b1;
          bmb_d[wi] = bomb;
          num_d[wi] = in_number;
        end
      end
      BLAST: begin
        cnt_d = (cnt_q == CNTW'(GRID_CELLS - 1)) ? '0 : cnt_q + CNTW'(1);
        // Bomb flags stay set, so a bomb already flattened still goes off.
        if (bmb_q[cur]) begin
          occ_d[cur] = 1'b0;
          for (int unsigned d = 0; d < 6; d++) begin
            nb = nbr_cell(32'(cur[DIM_LOG2-1:0]), 32'(cur[2*DIM_LOG2-1:DIM_LOG2]),
                          32'(cur[CW-1:2*DIM_LOG2]), d, DIM_LOG2, WRAP != 0);
            if (nb.vld) begin
              occ_d[CW'(nb.c)] = 1'b0;
            end
          end
        end
      end
      SCAN: begin
        cnt_d    = cnt_q + CNTW'(1);
        s1_vld_d = (cnt_q < CNTW'(GRID_CELLS)) && occ_q[cur];
        s1_mul_d = 3'd6 - k_w;
        s1_num_d = num_q[cur];
        if (s1_vld_q) begin
          sum_w = EW'(acc_q) + EW'(s1_mul_q) * EW'(s1_num_q);
          acc_d = (sum_w[EW-1:SUM_W] != '0) ? '1 : sum_w[SUM_W-1:0];
        end
      end
      DONE: begin
        occ_d = '0;
        bmb_d = '0;
        num_d = '{default: '0};
        acc_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      occ_q    <= '0;
      bmb_q    <= '0;
      num_q    <= '{default: '0};
      s1_vld_q <= 1'b0;
      s1_mul_q <= '0;
      s1_num_q <= '0;
      acc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      bmb_q    <= bmb_d;
      num_q    <= num_d;
      s1_vld_q <= s1_vld_d;
      s1_mul_q <= s1_mul_d;
      s1_num_q <= s1_num_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_sns_grid_area.sv
// Drives the same voxel bursts into wrap, clip and narrow-sum instances and compares them to a grid model.
module tb_sns_grid_area;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_x, in_y, in_z, in_number;
  logic        bomb;
  logic        busy_a, busy_b, busy_c;
  logic        ov_a, ov_b, ov_c;
  logic [15:0] sum_a, sum_b;
  logic [10:0] sum_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int z;
    int num;
    bit b;
  } beat_t;

  beat_t  beats[$];
  longint got_a, got_b, got_c;

  sns_grid_area #(.WRAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .in_number(in_number), .bomb(bomb), .busy(busy_a), .out_valid(ov_a), .out_sum(sum_a)
  );

  sns_grid_area #(.WRAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .in_number(in_number), .bomb(bomb), .busy(busy_b), .out_valid(ov_b), .out_sum(sum_b)
  );

  sns_grid_area #(.SUM_W(11), .WRAP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .in_number(in_number), .bomb(bomb), .busy(busy_c), .out_valid(ov_c), .out_sum(sum_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Final grid after all writes, every bomb blast and the face sweep, using plain 3D arithmetic.
  function automatic longint model(input bit wrap, input longint maxv);
    bit     occ [8][8][8];
    int     num [8][8][8];
    bit     bmb [8][8][8];
    int     dx [6] = '{1, -1, 0, 0, 0, 0};
    int     dy [6] = '{0, 0, 1, -1, 0, 0};
    int     dz [6] = '{0, 0, 0, 0, 1, -1};
    longint acc = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int z = 0; z < 8; z++) begin
          occ[x][y][z] = 0; num[x][y][z] = 0; bmb[x][y][z] = 0;
        end
    foreach (beats[i]) begin
      occ[beats[i].x][beats[i].y][beats[i].z] = 1;
      num[beats[i].x][beats[i].y][beats[i].z] = beats[i].num;
      bmb[beats[i].x][beats[i].y][beats[i].z] = beats[i].b;
    end
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int z = 0; z < 8; z++)
          if (bmb[x][y][z]) begin
            occ[x][y][z] = 0;
            for (int d = 0; d < 6; d++) begin
              int nx, ny, nz;
              nx = x + dx[d]; ny = y + dy[d]; nz = z + dz[d];
              if (wrap) begin
                nx = (nx + 8) % 8; ny = (ny + 8) % 8; nz = (nz + 8) % 8;
                occ[nx][ny][nz] = 0;
              end else if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8 && nz >= 0 && nz < 8) begin
                occ[nx][ny][nz] = 0;
              end
            end
          end
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int z = 0; z < 8; z++)
          if (occ[x][y][z]) begin
            int k = 0;
            for (int d = 0; d < 6; d++) begin
              int nx, ny, nz;
              nx = x + dx[d]; ny = y + dy[d]; nz = z + dz[d];
              if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8 && nz >= 0 && nz < 8)
                k += occ[nx][ny][nz];
            end
            acc += (6 - k) * num[x][y][z];
            if (acc > maxv) acc = maxv;
          end
    return acc;
  endfunction

  task automatic add(input int x, input int y, input int z, input int num, input bit b);
    beat_t bt;
    bt.x = x; bt.y = y; bt.z = z; bt.num = num; bt.b = b;
    beats.push_back(bt);
  endtask

  task automatic gen_random(input int len, input int span);
    beats.delete();
    for (int i = 0; i < len; i++)
      add($urandom_range(0, span), $urandom_range(0, span), $urandom_range(0, span),
          $urandom_range(0, 7), ($urandom_range(0, 4) == 0));
  endtask

  task automatic drive_beats();
    foreach (beats[i]) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_x      = 3'(beats[i].x);
      in_y      = 3'(beats[i].y);
      in_z      = 3'(beats[i].z);
      in_number = 3'(beats[i].num);
      bomb      = beats[i].b;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // junk = 1 toggles in_valid and the voxel fields while busy; the DUTs must drop those beats.
  task automatic run_burst(input string tag, input bit junk);
    int lat  = 0;
    int leak = 0;
    bit seen = 0;
    drive_beats();
    while (lat < 2000 && !seen) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy_rise"}, busy_a, 1);
      if (ov_a) begin
        seen     = 1;
        in_valid = 1'b0;
      end else begin
        if (sum_a != 0 || sum_b != 0 || sum_c != 0) leak++;
        if (junk) begin
          in_valid  = 1'($urandom_range(0, 1));
          in_x      = 3'($urandom_range(0, 7));
          in_y      = 3'($urandom_range(0, 7));
          in_z      = 3'($urandom_range(0, 7));
          in_number = 3'($urandom_range(0, 7));
          bomb      = 1'($urandom_range(0, 1));
        end
      end
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_latency"}, lat, 1027);
    check({tag, "_sum_idle"}, leak, 0);
    check({tag, "_ov_all"}, {ov_b, ov_c}, 2'b11);
    got_a = sum_a; got_b = sum_b; got_c = sum_c;
    check({tag, "_wrap"}, got_a, model(1, 65535));
    check({tag, "_clip"}, got_b, model(0, 65535));
    check({tag, "_sat"}, got_c, model(1, 2047));
    @(negedge clk);
    check({tag, "_ov_drop"}, ov_a, 0);
    check({tag, "_busy_drop"}, busy_a, 0);
    check({tag, "_sum_drop"}, sum_a, 0);
  endtask

  initial begin
    int ov_cnt;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; in_number = '0; bomb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_ov", ov_a, 0);
    check("rst_sum", sum_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    beats.delete(); add(3, 3, 3, 5, 0);
    run_burst("single", 0);
    check("single_abs", got_a, 30);

    beats.delete(); add(0, 0, 0, 2, 0); add(1, 0, 0, 3, 0);
    run_burst("pair", 1);
    check("pair_abs", got_a, 25);

    beats.delete(); add(0, 0, 0, 7, 1); add(1, 0, 0, 1, 0); add(7, 0, 0, 4, 0);
    run_burst("bomb", 0);
    check("bomb_wrap_abs", got_a, 0);
    check("bomb_clip_abs", got_b, 24);

    beats.delete(); add(2, 2, 2, 3, 1); add(2, 2, 2, 4, 0);
    run_burst("dup", 1);
    check("dup_abs", got_a, 24);

    beats.delete(); add(4, 4, 4, 6, 1);
    run_burst("empty", 0);
    check("empty_abs", got_a, 0);

    beats.delete();
    for (int z = 0; z < 8; z++)
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) add(x, y, z, 7, 0);
    run_burst("full", 0);
    check("full_abs", got_a, 2688);
    check("full_sat_abs", got_c, 2047);

    for (int r = 0; r < 6; r++) begin
      gen_random($urandom_range(1, 60), (r % 2 == 0) ? 2 : 7);
      run_burst($sformatf("rand%0d", r), r[0]);
    end

    gen_random(40, 3);
    drive_beats();
    repeat (700) @(negedge clk);
    check("abort_busy_pre", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ov", ov_a, 0);
    check("abort_sum", sum_a, 0);
    check("abort_busy", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_cnt = 0;
    repeat (1100) begin
      @(negedge clk);
      if (ov_a || ov_b || ov_c) ov_cnt++;
    end
    check("abort_no_ov", ov_cnt, 0);
    beats.delete(); add(0, 0, 0, 1, 0);
    run_burst("post_abort", 0);
    check("post_abort_abs", got_a, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sns_grid_area.md
Name: sns_grid_area

Overview:
- Parametrised successor to the 8x8x8 stack-and-smash surface calculator.
- Loads a burst of voxels into an N×N×N occupancy/value grid, with N = 2^DIM_LOG2. Each voxel has a position, a NUM_W-bit weight and a bomb flag.
- Detonates all bombs, then sweeps the grid and returns the weighted exposed-face sum.
- Grid storage is internal flops, so there is no SRAM macro. A selectable wrap/clip bomb mode is added.

Parameters:
- DIM_LOG2, 3, log2 of grid edge; N = 2^DIM_LOG2, cell count = N^3.
- NUM_W, 3, width of the per-voxel weight.
- SUM_W, 16, width of out_sum (default covers 512×6×7 = 21504).
- WRAP, 1, bomb blast mode: 1 = neighbour coordinates wrap modulo N; 0 = out-of-grid neighbours ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  voxel beat valid
- in_x  in  DIM_LOG2  voxel x coordinate
- in_y  in  DIM_LOG2  voxel y coordinate
- in_z  in  DIM_LOG2  voxel z coordinate
- in_number  in  NUM_W  voxel weight
- bomb  in  1  voxel is a bomb
- busy  out  1  high from the first cycle after the burst ends until out_valid
- out_valid  out  1  single-cycle result strobe
- out_sum  out  SUM_W  weighted exposed-face sum; 0 whenever out_valid is low

Behaviour:
- Reset: state IDLE; grid occupancy, weights and bomb flags all 0; busy = 0, out_valid = 0, out_sum = 0.
- Cell index = z·N² + y·N + x. Raster order: x fastest, then y, then z.
- IDLE → LOAD on in_valid.
- LOAD:
  - Each in_valid cycle (including the first) sets occ[idx] = 1, num[idx] = in_number, bmb[idx] = bomb.
  - A duplicate coordinate overwrites: last write wins for both num and bmb.
  - First cycle with in_valid low → BLAST, and busy rises.
- BLAST:
  - N³ cycles, one cell per cycle in raster order.
  - If bmb[cell] = 1, clear occ of the cell and its 6 face neighbours.
  - WRAP = 1: neighbour coordinate is ±1 mod N. WRAP = 0: neighbours outside the grid are skipped.
  - Bomb flags are never cleared, so a bomb destroyed by an earlier bomb still detonates.
  - After the last cell → SCAN.
- SCAN:
  - N³ cycles in raster order, pipelined over 2 stages (neighbour count, multiply-accumulate).
  - For an occupied cell: acc += (6 − k) × num[cell], where k = number of occupied face neighbours. The neighbour count always clips at grid faces, so there is never wrap in SCAN.
  - Unoccupied cells add 0.
  - The accumulator saturates at 2^SUM_W − 1 and never wraps.
- DONE:
  - After the pipeline drains: out_valid = 1 and out_sum = acc for exactly one cycle.
  - Next cycle: out_valid = 0, out_sum = 0, busy = 0, state → IDLE; occ, num, bmb and acc are all cleared.
- Latency: out_valid is high exactly 2·N³ + 3 cycles after the first cycle in which in_valid is low (1027 cycles at defaults).
- in_valid while busy or in DONE is ignored; nothing is written.
- in_valid may be asserted again on the cycle after out_valid.
- A grid left empty after BLAST gives out_sum = 0 with unchanged latency.
- rst_n asserted in any state aborts immediately to reset values. No out_valid is produced for the aborted burst.

Decomposition:
- Shared package sns_pkg holds:
  - state enum {IDLE, LOAD, BLAST, SCAN, DONE};
  - derived constants N and CELLS;
  - a cell-index function idx(x, y, z);
  - the neighbour-coordinate function with a wrap/clip argument.
- One sub-module, sns_face_count: combinational. Takes the occupancy vector and a coordinate; returns k (0–6) with clipping. The top-level FSM, counters and accumulator stay in sns_grid_area.

Test Plan:
- Single voxel (3,3,3), num 5, no bomb → out_sum 30, out_valid exactly 1027 cycles after in_valid falls.
- Voxels (0,0,0) num 2 and (1,0,0) num 3 → out_sum 5·2 + 5·3 = 25.
- Bomb (0,0,0) num 7, plus (1,0,0) num 1 and (7,0,0) num 4:
  - WRAP = 1 → out_sum 0;
  - WRAP = 0 → (7,0,0) survives, out_sum 24.
- Duplicate (2,2,2): num 3 bomb 1, then num 4 bomb 0 → last write wins, out_sum 24.
- Full grid (512 beats), all num 7, no bombs → out_sum 384·7 = 2688. Repeat with SUM_W = 11 → saturates to 2047.
- Reset pulse mid-SCAN → out_valid 0, out_sum 0, busy 0. A following single-voxel burst (0,0,0) num 1 → out_sum 6, showing no residue from the aborted run.
